// File: rtl/serial_byte_assembler.sv
// serial_byte_assembler
// Collects a serial bit stream into WIDTH-bit words and presents each word
// on a single-entry valid/ready output buffer. A sticky overflow flag marks
// any completed word that had to be dropped because the buffer was full.
//
// state          | meaning
// ---------------+-----------------------------------------------
// COLLECT_EMPTY  | output buffer empty, collecting bits
// COLLECT_FULL   | output buffer holds an unconsumed word
module serial_byte_assembler #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    input  logic                     clear,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    output logic                     overflow,
    output logic [$clog2(WIDTH)-1:0] bit_count
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        COLLECT_EMPTY = 1'b0,
        COLLECT_FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] shifted;
    logic             accept;
    logic             last_bit;
    logic             complete;

    // Next-state logic: shift/count, buffer load, handshake and overflow
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        ovf_d   = ovf_q;

        if (MSB_FIRST) begin
            shifted = {shreg_q[WIDTH-2:0], bit_in};
        end else begin
            shifted = {bit_in, shreg_q[WIDTH-1:1]};
        end

        // clear wins over a bit presented in the same cycle
        accept   = bit_valid && !clear;
        last_bit = (cnt_q == CW'(WIDTH - 1));
        complete = accept && last_bit;

        if (clear) begin
            shreg_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else if (accept) begin
            shreg_d = shifted;
            cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            COLLECT_EMPTY: begin
                if (complete) begin
                    data_d  = shifted;
                    state_d = COLLECT_FULL;
                end
            end
            COLLECT_FULL: begin
                if (complete) begin
                    // a transfer in the same cycle frees the slot for the new word
                    if (out_ready) begin
                        data_d = shifted;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (out_ready) begin
                    state_d = COLLECT_EMPTY;
                end
            end
            default: state_d = COLLECT_EMPTY;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT_EMPTY;
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = (state_q == COLLECT_FULL);
    assign overflow  = ovf_q;
    assign bit_count = cnt_q;

endmodule

// File: tb/tb_serial_byte_assembler.sv
// Testbench for serial_byte_assembler: drives an LSB-first and an MSB-first
// instance with identical stimulus and compares both against a word-level
// reference model built from a queue of received bits.
module tb_serial_byte_assembler;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, bit_valid, bit_in, clear, out_ready;

    logic [W-1:0]  d_l, d_m;
    logic          v_l, v_m, o_l, o_m;
    logic [CW-1:0] c_l, c_m;

    serial_byte_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
        .clear(clear), .out_ready(out_ready), .out_data(d_l),
        .out_valid(v_l), .overflow(o_l), .bit_count(c_l)
    );

    serial_byte_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in),
        .clear(clear), .out_ready(out_ready), .out_data(d_m),
        .out_valid(v_m), .overflow(o_m), .bit_count(c_m)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: bits of the partial word in arrival order
    int           bits_q[$];
    logic         m_valid = 1'b0;
    logic         m_ovf   = 1'b0;
    logic [W-1:0] m_lsb   = '0;
    logic [W-1:0] m_msb   = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic bv, input logic bi, input logic clr,
                                input logic rdy, input logic rst);
        logic         done;
        logic [W-1:0] wl, wm;
        done = 1'b0;
        wl   = '0;
        wm   = '0;
        if (rst) begin
            bits_q.delete();
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_lsb   = '0;
            m_msb   = '0;
        end else begin
            if (clr) begin
                bits_q.delete();
                m_ovf = 1'b0;
            end else if (bv) begin
                bits_q.push_back(int'(bi));
                if (bits_q.size() == W) begin
                    done = 1'b1;
                    for (int i = 0; i < W; i++) begin
                        wl = wl | (W'(bits_q[i]) << i);
                        wm = wm | (W'(bits_q[i]) << (W - 1 - i));
                    end
                    bits_q.delete();
                end
            end
            if (done) begin
                if (!m_valid || rdy) begin
                    m_lsb   = wl;
                    m_msb   = wm;
                    m_valid = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // One clock: apply inputs, advance model at the edge, check #1 later
    task automatic step(input logic bv, input logic bi, input logic clr,
                        input logic rdy, input logic rst);
        bit_valid = bv;
        bit_in    = bi;
        clear     = clr;
        out_ready = rdy;
        reset     = rst;
        @(posedge clk);
        model_update(bv, bi, clr, rdy, rst);
        #1;
        chk("lsb_valid", v_l, m_valid);
        chk("msb_valid", v_m, m_valid);
        chk("lsb_data", d_l, m_lsb);
        chk("msb_data", d_m, m_msb);
        chk("lsb_overflow", o_l, m_ovf);
        chk("msb_overflow", o_m, m_ovf);
        chk("lsb_count", c_l, bits_q.size());
        chk("msb_count", c_m, bits_q.size());
    endtask

    // Send a word, bit i of pat first; optional random idle gaps before each bit
    task automatic send_word(input logic [W-1:0] pat, input logic rdy, input int max_gap);
        for (int i = 0; i < W; i++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
            step(1'b1, pat[i], 1'b0, rdy, 1'b0);
        end
    endtask

    initial begin
        logic [W-1:0] pat;
        pat = 8'h53;

        // reset
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_valid", v_l, 1'b0);
        chk("reset_data", d_l, 8'h00);

        // 1,1,0,0,1,0,1,0 back to back
        send_word(pat, 1'b1, 0);
        chk("lsb_word_53", d_l, 8'h53);
        chk("msb_word_ca", d_m, 8'hCA);
        chk("word_valid", v_l, 1'b1);
        chk("word_count0", c_l, 0);

        // same bits with 1-3 idle cycles in between
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < W; i++) begin
            int gap;
            gap = int'($urandom_range(1, 3));
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b1, pat[i], 1'b0, 1'b1, 1'b0);
        end
        chk("gap_msb_ca", d_m, 8'hCA);
        chk("gap_valid", v_m, 1'b1);

        // backpressure: 0x53 then all ones with out_ready low
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_word(pat, 1'b0, 0);
        send_word(8'hFF, 1'b0, 0);
        chk("bp_data", d_l, 8'h53);
        chk("bp_overflow", o_l, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_drained", v_l, 1'b0);

        // full rate: 24 random bits with out_ready high
        for (int i = 0; i < 3 * W; i++) step(1'b1, 1'(($urandom % 2)), 1'b0, 1'b1, 1'b0);
        chk("fullrate_overflow", o_l, 1'b1);   // still sticky from backpressure
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);    // clear the sticky flag

        // out_ready pulse coinciding with completion
        send_word(8'h3C, 1'b0, 0);
        for (int i = 0; i < W - 1; i++) step(1'b1, 1'((8'hA5 >> i) & 1), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("pulse_valid", v_l, 1'b1);
        chk("pulse_data", d_l, 8'hA5);
        chk("pulse_overflow", o_l, 1'b0);

        // clear while out_valid=1 keeps the buffer; clear mid-word with a bit
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("clear_count", c_l, 0);
        chk("clear_keeps_data", d_l, 8'hA5);
        chk("clear_keeps_valid", v_l, 1'b1);
        send_word(8'h96, 1'b1, 0);
        chk("fresh_word", d_l, 8'h96);

        // reset mid-word with a buffered word
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_valid", v_l, 1'b0);
        chk("rst_data", d_m, 8'h00);
        chk("rst_count", c_l, 0);
        send_word(8'h71, 1'b0, 0);
        chk("post_rst_word", d_l, 8'h71);

        // random phase
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, 1'(($urandom % 2)), ($urandom % 20) == 0,
                 1'(($urandom % 2)), ($urandom % 64) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
